div_unit: RTL and testbench



---
 rtl/div_unit.sv | 159 +++++++++++++++
 tb/tb_div_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU and W variants.
// One quotient bit per cycle; divide-by-zero, signed overflow and bad func3 finish in one cycle.
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_div_i,
  input  logic            request_i,
  input  logic [2:0]      func3_i,
  input  logic            int_32_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o,
  output logic            done_tick_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [63:0] MIN_64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN_32 = 64'hFFFF_FFFF_8000_0000;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  logic [1:0]  r_state;
  logic [63:0] r_rem;
  logic [63:0] r_quo;
  logic [63:0] r_divisor;
  logic [6:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_is_rem;
  logic        r_w;
  logic [63:0] r_result;

  logic        w_accept;
  logic        w_signed;
  logic [63:0] w_a;
  logic [63:0] w_b;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_a_mag;
  logic [63:0] w_b_mag;
  logic        w_div0;
  logic        w_ovf;
  logic        w_fast;
  logic [63:0] w_fast_raw;
  logic [63:0] w_fast_res;

  assign w_accept = (r_state == S_IDLE) && request_i && !kill_div_i;

  // Operand preparation: W extension, sign detection, magnitudes and fast-path result.
  // NOTE: every signal assigned in an always_comb gets a default first so no path infers a latch.
  always_comb begin
    w_signed   = !func3_i[0];
    w_a        = src1_i;
    w_b        = src2_i;
    w_fast_raw = '0;
    if (int_32_i) begin
      w_a = w_signed ? sext32(src1_i[31:0]) : {32'b0, src1_i[31:0]};
      w_b = w_signed ? sext32(src2_i[31:0]) : {32'b0, src2_i[31:0]};
    end
    w_a_neg = w_signed && w_a[63];
    w_b_neg = w_signed && w_b[63];
    w_a_mag = w_a_neg ? (64'd0 - w_a) : w_a;
    w_b_mag = w_b_neg ? (64'd0 - w_b) : w_b;
    w_div0  = (w_b == 64'd0);
    w_ovf   = w_signed && (w_a == (int_32_i ? MIN_32 : MIN_64)) && (&w_b);
    w_fast  = !func3_i[2] || w_div0 || w_ovf;
    if (!func3_i[2])  w_fast_raw = '0;
    else if (w_div0)  w_fast_raw = func3_i[1] ? w_a : '1;
    else if (w_ovf)   w_fast_raw = func3_i[1] ? 64'd0 : w_a;
    w_fast_res = int_32_i ? sext32(w_fast_raw[31:0]) : w_fast_raw;
  end

  logic [64:0] w_shift_rem;
  logic        w_ge;
  logic [63:0] w_rem_next;
  logic [63:0] w_quo_next;
  logic [63:0] w_q_fix;
  logic [63:0] w_r_fix;
  logic [63:0] w_sel;
  logic [63:0] w_final;

  // Restoring step: the 65-bit shifted remainder keeps the carry-out visible to the compare.
  always_comb begin
    w_shift_rem = {r_rem, r_quo[63]};
    w_ge        = (w_shift_rem >= {1'b0, r_divisor});
    w_rem_next  = w_ge ? (w_shift_rem[63:0] - r_divisor) : w_shift_rem[63:0];
    w_quo_next  = {r_quo[62:0], w_ge};
    w_q_fix     = r_neg_q ? (64'd0 - w_quo_next) : w_quo_next;
    w_r_fix     = r_neg_r ? (64'd0 - w_rem_next) : w_rem_next;
    w_sel       = r_is_rem ? w_r_fix : w_q_fix;
    w_final     = r_w ? sext32(w_sel[31:0]) : w_sel;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
      r_w       <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= S_DONE;
            end else begin
              r_rem     <= '0;
              // W operands are left-aligned so the 32 iterations consume the low word MSB first.
              r_quo     <= int_32_i ? {w_a_mag[31:0], 32'b0} : w_a_mag;
              r_divisor <= w_b_mag;
              r_cnt     <= int_32_i ? 7'd32 : 7'd64;
              r_neg_q   <= w_a_neg ^ w_b_neg;
              r_neg_r   <= w_a_neg;
              r_is_rem  <= func3_i[1];
              r_w       <= int_32_i;
              r_state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (kill_div_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - 7'd1;
            if (r_cnt == 7'd1) begin
              r_result <= w_final;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done_tick_o = (r_state == S_DONE) && !kill_div_i;
  assign stall_o     = !kill_div_i && ((r_state == S_BUSY) || ((r_state == S_IDLE) && request_i));
  assign result_o    = done_tick_o ? r_result : '0;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: open-loop driver plus a monitor that models
// results and cycle-exact latency from the instruction semantics.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        kill_div_i;
  logic        request_i;
  logic [2:0]  func3_i;
  logic        int_32_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic [63:0] result_o;
  logic        stall_o;
  logic        done_tick_o;

  always #5 clk_i = ~clk_i;

  div_unit #(.XLEN(64)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .kill_div_i  (kill_div_i),
    .request_i   (request_i),
    .func3_i     (func3_i),
    .int_32_i    (int_32_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .result_o    (result_o),
    .stall_o     (stall_o),
    .done_tick_o (done_tick_o)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Hand-computed expectations handed from driver to monitor for directed ops.
  logic        lit_valid = 1'b0;
  logic [63:0] lit_result = '0;
  int          lit_lat = 0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [63:0] model_result(input logic [2:0] f3, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, s32;
    logic [63:0] q, r;
    if (!f3[2]) return 64'd0;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32;
      end else if (!f3[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (!f3[0]) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      s32 = f3[1] ? r32 : q32;
      return {{32{s32[31]}}, s32};
    end
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = 64'd0;
    end else if (!f3[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int model_latency(input logic [2:0] f3, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (w) begin
      zero = (b[31:0] == 32'd0);
      ovf  = !f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      zero = (b == 64'd0);
      ovf  = !f3[0] && a == 64'h8000_0000_0000_0000 && b == '1;
    end
    if (!f3[2] || zero || ovf) return 1;
    return w ? 33 : 65;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  // Monitor: tracks the op in flight from observed inputs and checks every cycle mid-period.
  initial begin
    logic        pend;
    int          t_done;
    int          lat;
    logic [63:0] exp_res;
    logic        m_lit;
    logic [63:0] m_lit_res;
    pend = 1'b0;
    t_done = 0;
    exp_res = '0;
    m_lit = 1'b0;
    m_lit_res = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        pend = 1'b0;
      end else if (pend && kill_div_i) begin
        check1("kill_stall", stall_o, 1'b0);
        check1("kill_done", done_tick_o, 1'b0);
        check("kill_result", result_o, 64'd0);
        pend = 1'b0;
      end else if (pend) begin
        if (cyc < t_done) begin
          check1("busy_stall", stall_o, 1'b1);
          check1("busy_done", done_tick_o, 1'b0);
          check("busy_result", result_o, 64'd0);
        end else begin
          check1("done_tick", done_tick_o, 1'b1);
          check1("done_stall", stall_o, 1'b0);
          check("result", result_o, exp_res);
          if (m_lit) check("lit_result", result_o, m_lit_res);
          pend = 1'b0;
        end
      end else begin
        check1("idle_done", done_tick_o, 1'b0);
        check("idle_result", result_o, 64'd0);
        if (request_i && !kill_div_i) begin
          check1("accept_stall", stall_o, 1'b1);
          exp_res = model_result(func3_i, int_32_i, src1_i, src2_i);
          lat     = model_latency(func3_i, int_32_i, src1_i, src2_i);
          t_done  = cyc + lat;
          m_lit     = lit_valid;
          m_lit_res = lit_result;
          if (lit_valid) check("lit_latency", 64'(lat), 64'(lit_lat));
          pend = 1'b1;
        end else begin
          check1("idle_stall", stall_o, 1'b0);
        end
      end
    end
  end

  // Issue one op, optionally pulse junk requests and scramble inputs while it runs,
  // and return in the cycle right after its DONE cycle (plus gap idle cycles).
  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input int gap, input logic lv,
                       input logic [63:0] lr, input int ll, input logic junk);
    int lat;
    lat        = model_latency(f3, w, a, b);
    lit_valid  = lv;
    lit_result = lr;
    lit_lat    = ll;
    func3_i    = f3;
    int_32_i   = w;
    src1_i     = a;
    src2_i     = b;
    request_i  = 1'b1;
    for (int k = 0; k < lat; k++) begin
      @(posedge clk_i); #1;
      request_i = junk && ($urandom_range(0, 3) == 0);
      if (junk) begin
        func3_i  = 3'($urandom_range(0, 7));
        int_32_i = 1'($urandom_range(0, 1));
        src1_i   = {$urandom, $urandom};
        src2_i   = {$urandom, $urandom};
      end
    end
    @(posedge clk_i); #1;
    request_i = 1'b0;
    lit_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    int          kind;
    rst_i      = 1'b1;
    kill_div_i = 1'b0;
    request_i  = 1'b0;
    func3_i    = 3'd0;
    int_32_i   = 1'b0;
    src1_i     = '0;
    src2_i     = '0;
    idle_cycles(3);
    rst_i = 1'b0;
    idle_cycles(2);

    // Directed ops with literal results; gap 0 exercises accept right after DONE.
    do_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 65, 1'b0);
    do_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
    do_op(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 0, 1'b1, 64'h0000_0000_7FFF_FFFF, 33, 1'b1);
    do_op(3'b111, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 0, 1'b1, 64'h0000_0000_0000_0001, 33, 1'b1);
    do_op(3'b101, 1'b0, 64'h1234, 64'd0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    do_op(3'b111, 1'b0, 64'h1234, 64'd0, 1, 1'b1, 64'h0000_0000_0000_1234, 1, 1'b0);
    do_op(3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);
    do_op(3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 1'b1, 64'd0, 1, 1'b0);
    do_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 1'b1, 64'h8000_0000_0000_0000, 1, 1'b0);
    do_op(3'b011, 1'b0, 64'd50, 64'd5, 1, 1'b1, 64'd0, 1, 1'b0);
    do_op(3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b1);

    // Kill in BUSY at cycle 10, then DIVU 100/7 issued at cycle 12.
    lit_valid = 1'b0;
    func3_i = 3'b100; int_32_i = 1'b0; src1_i = 64'd100; src2_i = 64'd7;
    request_i = 1'b1;
    idle_cycles(1);
    request_i = 1'b0;
    idle_cycles(9);
    kill_div_i = 1'b1;
    idle_cycles(1);
    kill_div_i = 1'b0;
    idle_cycles(1);
    do_op(3'b101, 1'b0, 64'd100, 64'd7, 1, 1'b1, 64'd14, 65, 1'b0);

    // Kill while IDLE blocks acceptance.
    func3_i = 3'b101; src1_i = 64'd9; src2_i = 64'd3;
    request_i = 1'b1; kill_div_i = 1'b1;
    idle_cycles(1);
    request_i = 1'b0; kill_div_i = 1'b0;
    idle_cycles(2);

    // Kill in DONE suppresses the tick.
    func3_i = 3'b101; int_32_i = 1'b0; src1_i = 64'd9; src2_i = 64'd0;
    request_i = 1'b1;
    idle_cycles(1);
    request_i = 1'b0; kill_div_i = 1'b1;
    idle_cycles(1);
    kill_div_i = 1'b0;
    idle_cycles(2);

    // Reset in cycle 20 of a 64-bit DIV, then a normal op.
    func3_i = 3'b100; int_32_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd3;
    request_i = 1'b1;
    idle_cycles(1);
    request_i = 1'b0;
    idle_cycles(19);
    rst_i = 1'b1;
    idle_cycles(1);
    rst_i = 1'b0;
    idle_cycles(2);
    do_op(3'b110, 1'b0, 64'd1000, 64'd3, 0, 1'b1, 64'd1, 65, 1'b0);

    // Randomized ops covering all func3 codes, both widths and the fast-path corners.
    for (int i = 0; i < 60; i++) begin
      f3   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      w    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 5);
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      case (kind)
        1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 40)); end
        2: b = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, 32'd0};
        3: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
        end
        4: b = {48'd0, 16'($urandom)} | 64'd1;
        5: begin a = -64'($urandom_range(0, 5000)); b = -64'($urandom_range(1, 99)); end
        default: ;
      endcase
      do_op(f3, w, a, b, $urandom_range(0, 2), 1'b0, 64'd0, 0, 1'b1);
    end

    idle_cycles(3);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
